// File: rtl/ui_overlay_pkg.sv
// ui_overlay_pkg: shared descriptor layout, default geometry and helpers for
// the UI overlay engine and its per-slot matcher.
package ui_overlay_pkg;

  localparam int DEF_SLOTS        = 16;
  localparam int DEF_ATLAS_W      = 360;
  localparam int DEF_ATLAS_H      = 240;
  localparam int DEF_ADDR_W       = 17;
  localparam int DEF_COORD_W      = 9;
  localparam int DEF_SCALE_SHIFT  = 1;
  localparam int DEF_BLINK_FRAMES = 30;

  // Descriptor packing, MSB first: {en, blink, x0, y0, w, h, u0, v0}.
  // Coordinate fields are numbered from the LSB end.
  typedef enum int {
    F_V0 = 0,
    F_U0 = 1,
    F_H  = 2,
    F_W  = 3,
    F_Y0 = 4,
    F_X0 = 5
  } coord_field_e;

  // Descriptor view at the default coordinate width.
  typedef struct packed {
    logic       en;
    logic       blink;
    logic [8:0] x0;
    logic [8:0] y0;
    logic [8:0] w;
    logic [8:0] h;
    logic [8:0] u0;
    logic [8:0] v0;
  } desc_t;

  function automatic int desc_w(input int coord_w);
    return 2 + 6 * coord_w;
  endfunction

  function automatic int field_lsb(input coord_field_e f, input int coord_w);
    return int'(f) * coord_w;
  endfunction

  function automatic int blink_bit(input int coord_w);
    return 6 * coord_w;
  endfunction

  function automatic int en_bit(input int coord_w);
    return 6 * coord_w + 1;
  endfunction

  // First visible pixel of a frame.
  function automatic logic is_frame_start(input logic       pix_valid,
                                          input logic [9:0] h_cnt,
                                          input logic [9:0] v_cnt);
    return pix_valid && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  endfunction

endpackage

// File: rtl/ui_slot_match.sv
// ui_slot_match: combinational hit test of one logical pixel against one
// sprite descriptor, plus the atlas-local texel coordinates of that pixel.
// Extents are summed one bit wider than the coordinates so that x0+w and
// y0+h never wrap; a zero width or height therefore never hits.
module ui_slot_match
  import ui_overlay_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  localparam int DESC_W = desc_w(COORD_W)
) (
  input  logic [DESC_W-1:0]  desc,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               hide_blink,
  output logic               hit,
  output logic [COORD_W:0]   lu,
  output logic [COORD_W:0]   lv
);

  localparam int X0_LSB = field_lsb(F_X0, COORD_W);
  localparam int Y0_LSB = field_lsb(F_Y0, COORD_W);
  localparam int W_LSB  = field_lsb(F_W, COORD_W);
  localparam int H_LSB  = field_lsb(F_H, COORD_W);
  localparam int U0_LSB = field_lsb(F_U0, COORD_W);
  localparam int V0_LSB = field_lsb(F_V0, COORD_W);
  localparam int EN_B   = en_bit(COORD_W);
  localparam int BL_B   = blink_bit(COORD_W);

  logic               en;
  logic               blink;
  logic [COORD_W-1:0] x0, y0, w, h, u0, v0;
  logic [COORD_W:0]   x_end, y_end;
  logic [COORD_W-1:0] dx, dy;
  logic               in_x, in_y;

  assign en    = desc[EN_B];
  assign blink = desc[BL_B];
  assign x0    = desc[X0_LSB +: COORD_W];
  assign y0    = desc[Y0_LSB +: COORD_W];
  assign w     = desc[W_LSB  +: COORD_W];
  assign h     = desc[H_LSB  +: COORD_W];
  assign u0    = desc[U0_LSB +: COORD_W];
  assign v0    = desc[V0_LSB +: COORD_W];

  assign x_end = {1'b0, x0} + {1'b0, w};
  assign y_end = {1'b0, y0} + {1'b0, h};

  assign in_x = (x >= x0) && ({1'b0, x} < x_end);
  assign in_y = (y >= y0) && ({1'b0, y} < y_end);

  assign hit = en && !(blink && hide_blink) && in_x && in_y;

  // Offsets are only meaningful when hit; the winner mux discards the rest.
  assign dx = x - x0;
  assign dy = y - y0;
  assign lu = {1'b0, dx} + {1'b0, u0};
  assign lv = {1'b0, dy} + {1'b0, v0};

endmodule

// File: rtl/ui_overlay_engine.sv
// ui_overlay_engine: resolves each VGA pixel to a sprite-atlas address using
// a double-buffered table of SLOTS descriptors. Two-cycle pipeline:
//   stage 1 registers per-slot hit vector and atlas-local offsets,
//   stage 2 priority-encodes (lowest slot wins) and forms the atlas address.
// The shadow table is published to the active table in the frame-start
// cycle, and that frame-start pixel already sees the new table.
// Optional feature: define UI_OVERLAY_BLINK_EN to enable sprite blinking.
module ui_overlay_engine
  import ui_overlay_pkg::*;
#(
  parameter int SLOTS        = DEF_SLOTS,
  parameter int ATLAS_W      = DEF_ATLAS_W,
  parameter int ATLAS_H      = DEF_ATLAS_H,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int SCALE_SHIFT  = DEF_SCALE_SHIFT,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int DESC_W      = desc_w(COORD_W),
  localparam int SLOT_W      = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              pix_valid,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [SLOT_W-1:0] desc_slot,
  input  logic [DESC_W-1:0] desc_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              isObject,
  output logic [SLOT_W-1:0] hit_slot
);

  localparam int ATLAS_SZ = ATLAS_W * ATLAS_H;

  logic [DESC_W-1:0]  shadow_tbl [SLOTS];
  logic [DESC_W-1:0]  active_tbl [SLOTS];
  logic [DESC_W-1:0]  eff_tbl    [SLOTS];

  logic               frame_start;
  logic               swap;
  logic               wr_accept;
  logic               hide_blink;
  logic [COORD_W-1:0] pix_x, pix_y;

  logic [SLOTS-1:0]   m_hit;
  logic [COORD_W:0]   m_lu [SLOTS];
  logic [COORD_W:0]   m_lv [SLOTS];

  logic               s1_valid;
  logic [SLOTS-1:0]   s1_hit;
  logic [COORD_W:0]   s1_lu [SLOTS];
  logic [COORD_W:0]   s1_lv [SLOTS];

  logic               win_found;
  logic [SLOT_W-1:0]  win_idx;
  logic [COORD_W:0]   win_lu, win_lv;
  logic [ADDR_W-1:0]  win_addr;

  assign frame_start = is_frame_start(pix_valid, h_cnt, v_cnt);
  assign swap        = frame_start && (commit_pending || commit);
  // The swap cycle is the only cycle the shadow table is being copied.
  assign desc_ready  = !swap;
  assign wr_accept   = desc_valid && desc_ready;

  assign pix_x = COORD_W'(h_cnt >> SCALE_SHIFT);
  assign pix_y = COORD_W'(v_cnt >> SCALE_SHIFT);

  // Shadow table: whole-slot overwrite on each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) shadow_tbl[i] <= '0;
    end else if (wr_accept) begin
      shadow_tbl[desc_slot] <= desc_data;
    end
  end

  // Active table: atomic copy of the shadow table at a committed frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) active_tbl[i] <= '0;
    end else if (swap) begin
      for (int i = 0; i < SLOTS; i++) active_tbl[i] <= shadow_tbl[i];
    end
  end

  // Commit request held until the next frame start consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_pending <= 1'b0;
    end else if (swap) begin
      commit_pending <= 1'b0;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end
  end

`ifdef UI_OVERLAY_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase;
  logic            frame_phase;

  // Frame counter and blink phase. frame_phase holds the phase a frame was
  // started with, so a phase toggle takes effect from the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_phase <= 1'b0;
    end else if (frame_start) begin
      frame_phase <= blink_phase;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign hide_blink = frame_start ? blink_phase : frame_phase;
`else
  assign hide_blink = 1'b0;
`endif

  // The frame-start pixel must see the table being published this cycle.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign eff_tbl[g] = swap ? shadow_tbl[g] : active_tbl[g];

    ui_slot_match #(
      .COORD_W (COORD_W)
    ) u_match (
      .desc       (eff_tbl[g]),
      .x          (pix_x),
      .y          (pix_y),
      .hide_blink (hide_blink),
      .hit        (m_hit[g]),
      .lu         (m_lu[g]),
      .lv         (m_lv[g])
    );
  end

  // Stage 1: per-slot hit vector and atlas-local offsets.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        s1_lu[i] <= '0;
        s1_lv[i] <= '0;
      end
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= pix_valid ? m_hit : '0;
      for (int i = 0; i < SLOTS; i++) begin
        s1_lu[i] <= m_lu[i];
        s1_lv[i] <= m_lv[i];
      end
    end
  end

  // Stage 2 select: lowest hitting slot wins, scanned high to low.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_lu    = '0;
    win_lv    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_found = 1'b1;
        win_idx   = SLOT_W'(i);
        win_lu    = s1_lu[i];
        win_lv    = s1_lv[i];
      end
    end
  end

  // Atlas address, folded into the atlas so offsets past the last row wrap.
  always_comb begin
    win_addr = ADDR_W'((32'(win_lu) + 32'(win_lv) * 32'(ATLAS_W)) % 32'(ATLAS_SZ));
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      isObject   <= 1'b0;
      pixel_addr <= '0;
      hit_slot   <= '0;
    end else begin
      out_valid  <= s1_valid;
      isObject   <= win_found;
      pixel_addr <= win_found ? win_addr : '0;
      hit_slot   <= win_idx;
    end
  end

endmodule

// File: tb/tb_ui_overlay_engine.sv
// Directed bench for ui_overlay_engine: table of pixel probes plus
// hand-written sequences for commit timing, overlap priority, reset and blink.
module tb_ui_overlay_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic        pix_valid;
  logic        desc_valid;
  logic        desc_ready;
  logic [3:0]  desc_slot;
  logic [55:0] desc_data;
  logic        commit;
  logic        commit_pending;
  logic        out_valid;
  logic [16:0] pixel_addr;
  logic        isObject;
  logic [3:0]  hit_slot;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ui_overlay_engine #(
    .BLINK_FRAMES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .h_cnt          (h_cnt),
    .v_cnt          (v_cnt),
    .pix_valid      (pix_valid),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_slot      (desc_slot),
    .desc_data      (desc_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .out_valid      (out_valid),
    .pixel_addr     (pixel_addr),
    .isObject       (isObject),
    .hit_slot       (hit_slot)
  );

  typedef struct {
    int    h;
    int    v;
    logic  obj;
    int    addr;
    int    slot;
    string name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(int h, int v, logic obj, int addr, int slot, string name);
    vec_t r;
    r.h = h; r.v = v; r.obj = obj; r.addr = addr; r.slot = slot; r.name = name;
    return r;
  endfunction

  function automatic logic [55:0] mk_desc(logic en, logic blink, int x0, int y0,
                                          int w, int h, int u0, int v0);
    logic [8:0] fx0, fy0, fw, fh, fu0, fv0;
    fx0 = x0[8:0]; fy0 = y0[8:0]; fw = w[8:0]; fh = h[8:0]; fu0 = u0[8:0]; fv0 = v0[8:0];
    return {en, blink, fx0, fy0, fw, fh, fu0, fv0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_desc(int slot, logic [55:0] d);
    desc_valid = 1'b1;
    desc_slot  = slot[3:0];
    desc_data  = d;
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  // One pixel in, idle, then compare the registered result two edges later.
  task automatic probe(string name, int h, int v, logic com, logic chk_ready,
                       logic exp_obj, int exp_addr, int exp_slot);
    logic [3:0]  es;
    logic [16:0] ea;
    es = exp_slot[3:0];
    ea = exp_addr[16:0];
    h_cnt = h[9:0]; v_cnt = v[9:0]; pix_valid = 1'b1; commit = com;
    if (chk_ready) begin
      #1;
      check({name, ".desc_ready"}, {31'd0, desc_ready}, 32'd0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; commit = 1'b0;
    @(posedge clk); #1;
    check(name, {9'd0, out_valid, isObject, hit_slot, pixel_addr},
          {9'd0, 1'b1, exp_obj, es, ea});
  endtask

  task automatic check_idle_outputs(string name);
    check(name, {12'd0, out_valid, isObject, commit_pending, hit_slot, pixel_addr},
          32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; h_cnt = '0; v_cnt = '0; pix_valid = 1'b0;
    desc_valid = 1'b0; desc_slot = '0; desc_data = '0; commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_idle", {31'd0, desc_ready}, 32'd1);

    // ---- basic table ----
    write_desc(0, mk_desc(1, 0, 120, 120, 80, 20, 0, 40));
    write_desc(1, mk_desc(1, 0, 0, 0, 10, 10, 0, 239));
    write_desc(3, mk_desc(1, 0, 300, 50, 100, 10, 0, 0));
    write_desc(4, mk_desc(1, 0, 10, 60, 0, 10, 0, 0));
    probe("precommit_empty", 260, 250, 0, 0, 0, 0, 0);
    pulse_commit();
    check("pending_set", {31'd0, commit_pending}, 32'd1);
    probe("fs_new_table", 0, 0, 0, 1, 1, 86040, 1);
    check("pending_clear", {31'd0, commit_pending}, 32'd0);

    vecs.push_back(mkv(260, 250, 1, 16210, 0, "s0_mid"));
    vecs.push_back(mkv(240, 240, 1, 14400, 0, "s0_topleft"));
    vecs.push_back(mkv(399, 279, 1, 21319, 0, "s0_botright"));
    vecs.push_back(mkv(400, 240, 0, 0, 0, "s0_right_edge"));
    vecs.push_back(mkv(238, 240, 0, 0, 0, "s0_left_out"));
    vecs.push_back(mkv(240, 280, 0, 0, 0, "s0_bottom_edge"));
    vecs.push_back(mkv(241, 241, 1, 14400, 0, "scale_shift"));
    vecs.push_back(mkv(2, 2, 1, 1, 1, "atlas_wrap"));
    vecs.push_back(mkv(600, 100, 1, 0, 3, "s3_x300"));
    vecs.push_back(mkv(638, 101, 1, 19, 3, "s3_x319"));
    vecs.push_back(mkv(598, 100, 0, 0, 0, "s3_x299"));
    vecs.push_back(mkv(600, 120, 0, 0, 0, "s3_y_edge"));
    vecs.push_back(mkv(20, 120, 0, 0, 0, "w0_slot"));
    foreach (vecs[i])
      probe(vecs[i].name, vecs[i].h, vecs[i].v, 0, 0, vecs[i].obj, vecs[i].addr, vecs[i].slot);

    // pix_valid low: no valid output two cycles later
    h_cnt = 10'd260; v_cnt = 10'd250; pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pix_invalid", {30'd0, out_valid, isObject}, 32'd0);

    // ---- mid-frame rewrite, deferred until frame start ----
    write_desc(0, mk_desc(1, 0, 120, 120, 80, 20, 100, 40));
    probe("nocommit_old", 260, 250, 0, 0, 1, 16210, 0);
    check("nocommit_pending", {31'd0, commit_pending}, 32'd0);
    pulse_commit();
    probe("pending_old", 260, 250, 0, 0, 1, 16210, 0);
    check("pending_held", {31'd0, commit_pending}, 32'd1);
    probe("fs_swap", 0, 0, 0, 1, 1, 86040, 1);
    check("pending_done", {31'd0, commit_pending}, 32'd0);
    probe("new_u0", 260, 250, 0, 0, 1, 16310, 0);

    // ---- overlap priority ----
    write_desc(0, mk_desc(0, 0, 120, 120, 80, 20, 100, 40));
    write_desc(2, mk_desc(1, 0, 100, 100, 50, 50, 0, 0));
    write_desc(5, mk_desc(1, 0, 125, 125, 20, 20, 5, 7));
    probe("fs_commit_same", 0, 0, 1, 1, 1, 86040, 1);
    check("pending_same_cycle", {31'd0, commit_pending}, 32'd0);
    probe("overlap_s2", 260, 260, 0, 0, 1, 10830, 2);
    probe("s2_only", 290, 290, 0, 0, 1, 16245, 2);
    write_desc(2, mk_desc(0, 0, 100, 100, 50, 50, 0, 0));
    pulse_commit();
    probe("s2_still", 260, 260, 0, 0, 1, 10830, 2);
    probe("fs_drop_s2", 0, 0, 0, 1, 1, 86040, 1);
    probe("overlap_s5", 260, 260, 0, 0, 1, 4330, 5);
    probe("s5_edge_miss", 290, 290, 0, 0, 0, 0, 0);

    // ---- reset with a pixel in flight and a commit pending ----
    pulse_commit();
    h_cnt = 10'd2; v_cnt = 10'd2; pix_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("rst_midframe");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("rst_flushed");
    probe("rst_fs_empty", 0, 0, 0, 0, 0, 0, 0);
    probe("rst_s1_gone", 2, 2, 0, 0, 0, 0, 0);
    probe("rst_s0_gone", 260, 250, 0, 0, 0, 0, 0);

    // ---- blink over frames 0..5 from a fresh reset ----
    do_reset();
    @(posedge clk); #1;
    write_desc(6, mk_desc(1, 1, 450, 450, 10, 10, 0, 0));
    probe("blink_uncommitted", 904, 904, 0, 0, 0, 0, 0);
    for (int f = 0; f < 6; f++) begin
      logic vis;
`ifdef UI_OVERLAY_BLINK_EN
      vis = ((f / 2) % 2) == 0;
`else
      vis = 1'b1;
`endif
      probe($sformatf("blink_fs%0d", f), 0, 0, (f == 0), 0, 0, 0, 0);
      probe($sformatf("blink_f%0d", f), 904, 904, 0, 0, vis, vis ? 722 : 0, vis ? 6 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
